// File: rtl/nlc_coeff_loader.sv
// nlc_coeff_loader: host-side coefficient writer for the 4-section NLC engine.
// Writes land in a shadow bank. A commit copies the shadow bank to the active
// bank in one cycle. The copy waits until the sample stream has been idle for
// GAP_CYCLES, so the NLC pipeline never mixes old and new coefficients.
// Optional feature: define NLC_COEFF_READBACK_EN to add the rd_sel/rd_addr/rd_data
// readback port.
module nlc_coeff_loader #(
    parameter int GAP_CYCLES     = 8,
    parameter int COMMIT_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          GlobalReset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [5:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          commit_req,
    output logic          commit_done,
    output logic          commit_err,
    output logic          addr_err,
    input  logic          srdyi,
`ifdef NLC_COEFF_READBACK_EN
    input  logic          rd_sel,
    input  logic [5:0]    rd_addr,
    output logic [31:0]   rd_data,
`endif
    output logic [1663:0] coeff_active,
    output logic [19:0]   section_limit
);

    localparam int NWORDS     = 52;
    localparam int LIMIT_ADDR = 52;
    localparam int GW         = $clog2(GAP_CYCLES + 1);
    localparam int TW         = $clog2(COMMIT_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(COMMIT_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_GAP, COPY} state_e;

    state_e                   state_q;
    logic [GW-1:0]            gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]            to_cnt_q, to_cnt_d;
    logic                     wr_ready_q, commit_done_q, commit_err_q, addr_err_q;
    logic [NWORDS-1:0][31:0]  shadow_q, active_q;
    logic [19:0]              shadow_lim_q, active_lim_q;
    logic                     wr_en, wr_mapped;

    assign wr_en     = wr_valid && wr_ready_q;
    assign wr_mapped = (wr_addr <= 6'(LIMIT_ADDR));

    assign wr_ready      = wr_ready_q;
    assign commit_done   = commit_done_q;
    assign commit_err    = commit_err_q;
    assign addr_err      = addr_err_q;
    assign coeff_active  = active_q;
    assign section_limit = active_lim_q;

    // Saturating next values for the idle-gap and timeout counters.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        if (srdyi)
            gap_cnt_d = '0;
        else if (gap_cnt_q != GAP_MAX)
            gap_cnt_d = gap_cnt_q + 1'b1;
        if (to_cnt_q != TO_MAX)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    // Commit FSM with registered handshake/status outputs; gap check beats timeout.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
            wr_ready_q    <= 1'b1;
            commit_done_q <= 1'b0;
            commit_err_q  <= 1'b0;
        end else begin
            commit_done_q <= 1'b0;
            commit_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (commit_req) begin
                        state_q    <= WAIT_GAP;
                        gap_cnt_q  <= '0;
                        to_cnt_q   <= '0;
                        wr_ready_q <= 1'b0;
                    end
                end
                WAIT_GAP: begin
                    if (gap_cnt_q >= GAP_MAX) begin
                        state_q <= COPY;
                    end else if (to_cnt_q >= TO_MAX) begin
                        state_q      <= IDLE;
                        commit_err_q <= 1'b1;
                        wr_ready_q   <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                        to_cnt_q  <= to_cnt_d;
                    end
                end
                COPY: begin
                    state_q       <= IDLE;
                    commit_done_q <= 1'b1;
                    wr_ready_q    <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Shadow bank: one accepted write per cycle; unmapped addresses are dropped.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            shadow_q     <= '0;
            shadow_lim_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NWORDS; i++)
                if (wr_addr == 6'(i)) shadow_q[i] <= wr_data;
            if (wr_addr == 6'(LIMIT_ADDR)) shadow_lim_q <= wr_data[19:0];
        end
    end

    // Sticky flag for writes that hit the unmapped hole.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n)
            addr_err_q <= 1'b0;
        else if (wr_en && !wr_mapped)
            addr_err_q <= 1'b1;
    end

    // Active bank: all words and the limit switch together on the COPY edge.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            active_q     <= '0;
            active_lim_q <= '0;
        end else if (state_q == COPY) begin
            active_q     <= shadow_q;
            active_lim_q <= shadow_lim_q;
        end
    end

`ifdef NLC_COEFF_READBACK_EN
    logic [31:0] rd_data_d, rd_data_q;
    assign rd_data = rd_data_q;

    // Readback mux: selected bank word, zero-extended limit, zero for the hole.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NWORDS; i++)
            if (rd_addr == 6'(i)) rd_data_d = rd_sel ? active_q[i] : shadow_q[i];
        if (rd_addr == 6'(LIMIT_ADDR))
            rd_data_d = {12'b0, (rd_sel ? active_lim_q : shadow_lim_q)};
    end

    // Readback register: data appears one cycle after the address.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end
`else
    // No readback path in this build.
`endif

endmodule

// File: tb/tb_nlc_coeff_loader.sv
// Directed bench for nlc_coeff_loader (GAP_CYCLES=8, COMMIT_TIMEOUT=16).
module tb_nlc_coeff_loader;
    localparam int GAP = 8;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          GlobalReset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [5:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          commit_req = 1'b0;
    logic          commit_done, commit_err, addr_err;
    logic          srdyi = 1'b0;
    logic [1663:0] coeff_active;
    logic [19:0]   section_limit;
`ifdef NLC_COEFF_READBACK_EN
    logic          rd_sel = 1'b0;
    logic [5:0]    rd_addr = '0;
    logic [31:0]   rd_data;
`endif

    int checks = 0;
    int errors = 0;

    nlc_coeff_loader #(.GAP_CYCLES(GAP), .COMMIT_TIMEOUT(TO)) dut (
        .clk(clk), .GlobalReset_n(GlobalReset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req), .commit_done(commit_done), .commit_err(commit_err),
        .addr_err(addr_err), .srdyi(srdyi),
`ifdef NLC_COEFF_READBACK_EN
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
`endif
        .coeff_active(coeff_active), .section_limit(section_limit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return coeff_active[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Issue a commit, optionally pulse srdyi after cycle pulse_at, and measure
    // cycles from the commit_req cycle to the done/err pulse (bounded).
    task automatic run_commit(input logic s_hold, input int pulse_at, output int lat,
                              output logic got_done, output logic got_err, output logic early);
        logic [1663:0] snap;
        snap = coeff_active;
        srdyi = s_hold;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        lat = 0; got_done = 1'b0; got_err = 1'b0; early = 1'b0;
        while (lat < 100 && !got_done && !got_err) begin
            tick();
            lat++;
            srdyi = (lat == pulse_at) ? 1'b1 : s_hold;
            got_done = commit_done;
            got_err  = commit_err;
            if (!got_done && coeff_active !== snap) early = 1'b1;
        end
        srdyi = 1'b0;
    endtask

    initial begin
        int lat;
        logic dn, er, ea;
        logic [1663:0] snap;

        // Reset state
        repeat (3) @(posedge clk);
        #1 GlobalReset_n = 1'b1;
        tick();
        chk("rst_bank_zero", 32'(coeff_active == '0), 32'd1);
        chk("rst_limit", 32'(section_limit), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("rst_done", 32'(commit_done), 32'h0);
        chk("rst_err", 32'(commit_err), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);

        // 1: basic commit, latency GAP+2
        wr(6'd5, 32'h12345678);
        run_commit(1'b0, -1, lat, dn, er, ea);
        chk("t1_latency", 32'(lat), 32'd10);
        chk("t1_done", 32'(dn), 32'h1);
        chk("t1_no_early", 32'(ea), 32'h0);
        chk("t1_word5", word(5), 32'h12345678);
        tick();
        chk("t1_done_pulse", 32'(commit_done), 32'h0);

        // 2: srdyi pulse in WAIT_GAP cycle 4 restarts the gap
        wr(6'd0, 32'hA5A5A5A5);
        run_commit(1'b0, 3, lat, dn, er, ea);
        chk("t2_latency", 32'(lat), 32'd14);
        chk("t2_done", 32'(dn), 32'h1);
        chk("t2_no_early", 32'(ea), 32'h0);
        chk("t2_word0", word(0), 32'hA5A5A5A5);

        // 3: timeout with srdyi held high
        wr(6'd1, 32'hDEADBEEF);
        run_commit(1'b1, -1, lat, dn, er, ea);
        chk("t3_latency", 32'(lat), 32'd17);
        chk("t3_err", 32'(er), 32'h1);
        chk("t3_no_done", 32'(dn), 32'h0);
        chk("t3_no_change", 32'(ea), 32'h0);
        chk("t3_word1_old", word(1), 32'h0);
        chk("t3_wr_ready", 32'(wr_ready), 32'h1);
        tick();
        chk("t3_err_pulse", 32'(commit_err), 32'h0);
        run_commit(1'b0, -1, lat, dn, er, ea);
        chk("t3_recommit_lat", 32'(lat), 32'd10);
        chk("t3_word1_new", word(1), 32'hDEADBEEF);

        // 4: write+commit same cycle, stalled write during WAIT_GAP
        wr_valid = 1'b1; wr_addr = 6'd52; wr_data = 32'h000ABCDE; commit_req = 1'b1;
        tick();
        commit_req = 1'b0; wr_addr = 6'd2; wr_data = 32'h0BADF00D;
        chk("t4_stall_ready", 32'(wr_ready), 32'h0);
        lat = 0;
        while (lat < 100 && !commit_done) begin
            tick();
            lat++;
        end
        chk("t4_latency", 32'(lat), 32'd10);
        chk("t4_limit", 32'(section_limit), 32'h000ABCDE);
        chk("t4_word2_not_yet", word(2), 32'h0);
        chk("t4_ready_at_done", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = 1'b0;
        run_commit(1'b0, -1, lat, dn, er, ea);
        chk("t4_word2_late", word(2), 32'h0BADF00D);
        chk("t4_limit_kept", 32'(section_limit), 32'h000ABCDE);
`ifdef NLC_COEFF_READBACK_EN
        rd_sel = 1'b1; rd_addr = 6'd52;
        tick();
        chk("rb_active_limit", rd_data, 32'h000ABCDE);
        rd_sel = 1'b0; rd_addr = 6'd60;
        tick();
        chk("rb_unmapped", rd_data, 32'h0);
        rd_addr = 6'd5;
        tick();
        chk("rb_shadow_w5", rd_data, 32'h12345678);
`endif

        // 5: unmapped write
        chk("t5_addr_err_pre", 32'(addr_err), 32'h0);
        wr(6'd60, 32'hFFFFFFFF);
        chk("t5_addr_err", 32'(addr_err), 32'h1);
        snap = coeff_active;
        run_commit(1'b0, -1, lat, dn, er, ea);
        chk("t5_done", 32'(dn), 32'h1);
        chk("t5_bank_same", 32'(coeff_active === snap), 32'h1);
        chk("t5_limit_same", 32'(section_limit), 32'h000ABCDE);
        repeat (3) tick();
        chk("t5_addr_err_sticky", 32'(addr_err), 32'h1);

        // 6: reset during WAIT_GAP
        wr(6'd5, 32'h00000055);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (3) tick();
        GlobalReset_n = 1'b0;
        #1;
        chk("t6_bank_zero", 32'(coeff_active == '0), 32'd1);
        chk("t6_limit", 32'(section_limit), 32'h0);
        chk("t6_wr_ready", 32'(wr_ready), 32'h1);
        chk("t6_addr_err", 32'(addr_err), 32'h0);
        chk("t6_done", 32'(commit_done), 32'h0);
`ifdef NLC_COEFF_READBACK_EN
        rd_sel = 1'b0; rd_addr = 6'd5;
`endif
        tick();
        GlobalReset_n = 1'b1;
        tick();
`ifdef NLC_COEFF_READBACK_EN
        chk("t6_rb_shadow_clr", rd_data, 32'h0);
`endif
        dn = 1'b0;
        repeat (14) begin
            tick();
            if (commit_done) dn = 1'b1;
        end
        chk("t6_commit_dropped", 32'(dn), 32'h0);
        chk("t6_word5_zero", word(5), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
